// File: rtl/execute_feedback_pkg.sv
// rtl/execute_feedback_pkg.sv - shared types and unit counts for execute-stage feedback
package execute_feedback_pkg;

  localparam int CFG_ALU_UNIT_NUM = 2;
  localparam int CFG_BRU_UNIT_NUM = 1;
  localparam int CFG_CSR_UNIT_NUM = 1;
  localparam int CFG_DIV_UNIT_NUM = 1;
  localparam int CFG_LSU_UNIT_NUM = 2;
  localparam int CFG_MUL_UNIT_NUM = 1;

  localparam int PHY_REG_ID_WIDTH = 6;
  localparam int EXECUTE_UNIT_NUM = CFG_ALU_UNIT_NUM + CFG_BRU_UNIT_NUM + CFG_CSR_UNIT_NUM
                                  + CFG_DIV_UNIT_NUM + CFG_LSU_UNIT_NUM + CFG_MUL_UNIT_NUM;

  typedef struct packed {
    logic                        enable;
    logic [PHY_REG_ID_WIDTH-1:0] phy_id;
    logic [31:0]                 value;
  } execute_feedback_channel_t;

  typedef struct packed {
    execute_feedback_channel_t [EXECUTE_UNIT_NUM-1:0] channel;
  } execute_feedback_pack_t;

  // A unit with zero channels still needs a one-entry port; the entry is never read.
  function automatic int port_len(input int n);
    return (n > 0) ? n : 1;
  endfunction

endpackage

// File: rtl/execute_feedback_pipe_reg.sv
// rtl/execute_feedback_pipe_reg.sv - generic one-stage pipeline register with synchronous clear
module execute_feedback_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= '0;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/execute_feedback.sv
// rtl/execute_feedback.sv - merges ALU/BRU/CSR/DIV/LSU/MUL feedback channels into one pack
module execute_feedback
  import execute_feedback_pkg::*;
#(
  parameter int ALU_UNIT_NUM = CFG_ALU_UNIT_NUM,
  parameter int BRU_UNIT_NUM = CFG_BRU_UNIT_NUM,
  parameter int CSR_UNIT_NUM = CFG_CSR_UNIT_NUM,
  parameter int DIV_UNIT_NUM = CFG_DIV_UNIT_NUM,
  parameter int LSU_UNIT_NUM = CFG_LSU_UNIT_NUM,
  parameter int MUL_UNIT_NUM = CFG_MUL_UNIT_NUM,
  parameter int OUTPUT_REG   = 0
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  execute_feedback_channel_t [port_len(ALU_UNIT_NUM)-1:0] alu_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [port_len(BRU_UNIT_NUM)-1:0] bru_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [port_len(CSR_UNIT_NUM)-1:0] csr_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [port_len(DIV_UNIT_NUM)-1:0] div_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [port_len(LSU_UNIT_NUM)-1:0] lsu_execute_channel_feedback_pack,
  input  execute_feedback_channel_t [port_len(MUL_UNIT_NUM)-1:0] mul_execute_channel_feedback_pack,
  output execute_feedback_pack_t                              execute_feedback_pack
);

  localparam int ALU_BASE = 0;
  localparam int BRU_BASE = ALU_BASE + ALU_UNIT_NUM;
  localparam int CSR_BASE = BRU_BASE + BRU_UNIT_NUM;
  localparam int DIV_BASE = CSR_BASE + CSR_UNIT_NUM;
  localparam int LSU_BASE = DIV_BASE + DIV_UNIT_NUM;
  localparam int MUL_BASE = LSU_BASE + LSU_UNIT_NUM;

  execute_feedback_pack_t w_pack;

  for (genvar i = 0; i < ALU_UNIT_NUM; i++) begin : g_alu
    assign w_pack.channel[ALU_BASE + i] = alu_execute_channel_feedback_pack[i];
  end

  for (genvar i = 0; i < BRU_UNIT_NUM; i++) begin : g_bru
    assign w_pack.channel[BRU_BASE + i] = bru_execute_channel_feedback_pack[i];
  end

  for (genvar i = 0; i < CSR_UNIT_NUM; i++) begin : g_csr
    assign w_pack.channel[CSR_BASE + i] = csr_execute_channel_feedback_pack[i];
  end

  for (genvar i = 0; i < DIV_UNIT_NUM; i++) begin : g_div
    assign w_pack.channel[DIV_BASE + i] = div_execute_channel_feedback_pack[i];
  end

  for (genvar i = 0; i < LSU_UNIT_NUM; i++) begin : g_lsu
    assign w_pack.channel[LSU_BASE + i] = lsu_execute_channel_feedback_pack[i];
  end

  for (genvar i = 0; i < MUL_UNIT_NUM; i++) begin : g_mul
    assign w_pack.channel[MUL_BASE + i] = mul_execute_channel_feedback_pack[i];
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    execute_feedback_pipe_reg #(
      .WIDTH($bits(execute_feedback_pack_t))
    ) u_pipe_reg (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (w_pack),
      .o_q   (execute_feedback_pack)
    );
  end else begin : g_out_comb
    // Combinational mode has no state, so clock and reset are deliberately sunk.
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;
    assign execute_feedback_pack = w_pack;
  end

endmodule

// File: tb/tb_execute_feedback.sv
// tb/tb_execute_feedback.sv - self-checking bench for execute_feedback in both output modes
module tb_execute_feedback;
  import execute_feedback_pkg::*;

  localparam int G_ALU = 0;
  localparam int G_BRU = 1;
  localparam int G_CSR = 2;
  localparam int G_DIV = 3;
  localparam int G_LSU = 4;
  localparam int G_MUL = 5;
  localparam int NVEC  = 8;

  typedef struct {
    int                        grp;
    int                        idx;
    execute_feedback_channel_t src;
    logic [2:0]                exp_ch;
  } vec_t;

  logic clk;
  logic rst;
  execute_feedback_channel_t [CFG_ALU_UNIT_NUM-1:0] alu;
  execute_feedback_channel_t [CFG_BRU_UNIT_NUM-1:0] bru;
  execute_feedback_channel_t [CFG_CSR_UNIT_NUM-1:0] csr;
  execute_feedback_channel_t [CFG_DIV_UNIT_NUM-1:0] div;
  execute_feedback_channel_t [CFG_LSU_UNIT_NUM-1:0] lsu;
  execute_feedback_channel_t [CFG_MUL_UNIT_NUM-1:0] mul;
  execute_feedback_pack_t out_comb;
  execute_feedback_pack_t out_reg;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [NVEC];

  execute_feedback #(.OUTPUT_REG(0)) dut_comb (
    .clk                               (clk),
    .rst                               (rst),
    .alu_execute_channel_feedback_pack (alu),
    .bru_execute_channel_feedback_pack (bru),
    .csr_execute_channel_feedback_pack (csr),
    .div_execute_channel_feedback_pack (div),
    .lsu_execute_channel_feedback_pack (lsu),
    .mul_execute_channel_feedback_pack (mul),
    .execute_feedback_pack             (out_comb)
  );

  execute_feedback #(.OUTPUT_REG(1)) dut_reg (
    .clk                               (clk),
    .rst                               (rst),
    .alu_execute_channel_feedback_pack (alu),
    .bru_execute_channel_feedback_pack (bru),
    .csr_execute_channel_feedback_pack (csr),
    .div_execute_channel_feedback_pack (div),
    .lsu_execute_channel_feedback_pack (lsu),
    .mul_execute_channel_feedback_pack (mul),
    .execute_feedback_pack             (out_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input execute_feedback_pack_t act,
                       input execute_feedback_pack_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    alu = '0; bru = '0; csr = '0; div = '0; lsu = '0; mul = '0;
  endtask

  task automatic set_src(input int grp, input int idx, input execute_feedback_channel_t c);
    case (grp)
      G_ALU:   alu[idx] = c;
      G_BRU:   bru[idx] = c;
      G_CSR:   csr[idx] = c;
      G_DIV:   div[idx] = c;
      G_LSU:   lsu[idx] = c;
      default: mul[idx] = c;
    endcase
  endtask

  function automatic execute_feedback_channel_t mk(input logic en, input logic [5:0] id,
                                                    input logic [31:0] val);
    execute_feedback_channel_t c;
    c.enable = en;
    c.phy_id = id;
    c.value  = val;
    return c;
  endfunction

  function automatic execute_feedback_channel_t rnd_chan();
    return mk(1'($urandom_range(0, 1)), 6'($urandom), $urandom);
  endfunction

  // Expected layout for 2 ALU, 1 BRU, 1 CSR, 1 DIV, 2 LSU, 1 MUL.
  function automatic execute_feedback_pack_t model();
    execute_feedback_pack_t m;
    m.channel[0] = alu[0];
    m.channel[1] = alu[1];
    m.channel[2] = bru[0];
    m.channel[3] = csr[0];
    m.channel[4] = div[0];
    m.channel[5] = lsu[0];
    m.channel[6] = lsu[1];
    m.channel[7] = mul[0];
    return m;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < CFG_ALU_UNIT_NUM; i++) alu[i] = rnd_chan();
    for (int i = 0; i < CFG_BRU_UNIT_NUM; i++) bru[i] = rnd_chan();
    for (int i = 0; i < CFG_CSR_UNIT_NUM; i++) csr[i] = rnd_chan();
    for (int i = 0; i < CFG_DIV_UNIT_NUM; i++) div[i] = rnd_chan();
    for (int i = 0; i < CFG_LSU_UNIT_NUM; i++) lsu[i] = rnd_chan();
    for (int i = 0; i < CFG_MUL_UNIT_NUM; i++) mul[i] = rnd_chan();
  endtask

  initial begin
    execute_feedback_pack_t exp;
    execute_feedback_pack_t held;

    vecs[0] = '{G_ALU, 0, mk(1'b1, 6'd5,    32'h1111_1111), 3'd0};
    vecs[1] = '{G_BRU, 0, mk(1'b1, 6'd6,    32'h2222_2222), 3'd2};
    vecs[2] = '{G_MUL, 0, mk(1'b1, 6'd63,   32'hFFFF_FFFF), 3'd7};
    vecs[3] = '{G_CSR, 0, mk(1'b0, 6'h2A,   32'hDEAD_BEEF), 3'd3};
    vecs[4] = '{G_ALU, 1, mk(1'b1, 6'd1,    32'hA5A5_A5A5), 3'd1};
    vecs[5] = '{G_DIV, 0, mk(1'b1, 6'h10,   32'h0000_0001), 3'd4};
    vecs[6] = '{G_LSU, 0, mk(1'b0, 6'd0,    32'h8000_0000), 3'd5};
    vecs[7] = '{G_LSU, 1, mk(1'b1, 6'h3F,   32'h0000_0000), 3'd6};

    rst = 1'b1;
    clear_inputs();
    #1;
    check("comb_idle", out_comb, '0);
    @(posedge clk); #1;
    check("reg_reset", out_reg, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      @(negedge clk);
      clear_inputs();
      set_src(vecs[v].grp, vecs[v].idx, vecs[v].src);
      exp = '0;
      exp.channel[vecs[v].exp_ch] = vecs[v].src;
      #1;
      check($sformatf("vec%0d_comb", v), out_comb, exp);
      @(posedge clk); #1;
      check($sformatf("vec%0d_reg", v), out_reg, exp);
    end

    // Three sources at once: first, BRU base, and last channel.
    @(negedge clk);
    clear_inputs();
    alu[0] = mk(1'b1, 6'd5,  32'h1111_1111);
    bru[0] = mk(1'b1, 6'd6,  32'h2222_2222);
    mul[0] = mk(1'b1, 6'd63, 32'hFFFF_FFFF);
    exp = '0;
    exp.channel[0] = mk(1'b1, 6'd5,  32'h1111_1111);
    exp.channel[2] = mk(1'b1, 6'd6,  32'h2222_2222);
    exp.channel[7] = mk(1'b1, 6'd63, 32'hFFFF_FFFF);
    #1;
    check("mapping_combined", out_comb, exp);

    // Duplicate phy_id on two enabled channels passes through untouched.
    @(negedge clk);
    clear_inputs();
    alu[1] = mk(1'b1, 6'd12, 32'h0000_00AA);
    lsu[1] = mk(1'b1, 6'd12, 32'h0000_00BB);
    exp = '0;
    exp.channel[1] = mk(1'b1, 6'd12, 32'h0000_00AA);
    exp.channel[6] = mk(1'b1, 6'd12, 32'h0000_00BB);
    #1;
    check("dup_phy_id", out_comb, exp);

    // Registered latency and mid-stream reset.
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    check("reg_cleared", out_reg, '0);
    @(negedge clk);
    lsu[0] = mk(1'b1, 6'd9, 32'h0000_1234);
    exp = '0;
    exp.channel[5] = mk(1'b1, 6'd9, 32'h0000_1234);
    #1;
    check("reg_before_edge", out_reg, '0);
    check("comb_lsu", out_comb, exp);
    @(posedge clk); #1;
    check("reg_after_edge", out_reg, exp);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reg_mid_reset", out_reg, '0);
    check("comb_ignores_rst", out_comb, exp);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 10000; s++) begin
      randomize_inputs();
      #1;
      check("rand_comb", out_comb, model());
    end

    for (int s = 0; s < 100; s++) begin
      @(negedge clk);
      randomize_inputs();
      held = model();
      @(posedge clk); #1;
      check("rand_reg", out_reg, held);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
